regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32 x 64-bit register file between two writeback sources: req0 (ALU writeback) and req1 (load writeback).
- Each source has a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter drains the buffers into registered write-port outputs: write enable, register number and 64-bit data.
- Writes to the zero register X31 are discarded and counted.

---
 rtl/regfile_write_arbiter_if.sv | 38 +++
 rtl/regfile_write_arbiter.sv | 128 ++++++++++++
 tb/tb_regfile_write_arbiter.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Write-port bundle of the register-file write arbiter: both writeback
// request channels and the registered write-port / statistics outputs.
interface regfile_write_arbiter_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 8
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [ADDR_WIDTH-1:0] req0_addr;
   logic [DATA_WIDTH-1:0] req0_data;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [ADDR_WIDTH-1:0] req1_addr;
   logic [DATA_WIDTH-1:0] req1_data;
   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  last_grant;
   logic [CNT_WIDTH-1:0]  write_count;
   logic [CNT_WIDTH-1:0]  drop_count;

   // Writeback sources side (drives requests, observes the write port)
   modport master (
      output req0_valid, req0_addr, req0_data,
      output req1_valid, req1_addr, req1_data,
      input  req0_ready, req1_ready,
      input  wr_en, wr_addr, wr_data, last_grant, write_count, drop_count
   );

   // Arbiter side
   modport slave (
      input  req0_valid, req0_addr, req0_data,
      input  req1_valid, req1_addr, req1_data,
      output req0_ready, req1_ready,
      output wr_en, wr_addr, wr_data, last_grant, write_count, drop_count
   );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: two one-entry holding buffers (ALU and load
// writeback) drained round-robin into a registered single write port.
// Writes aimed at the zero register are accepted, discarded and counted.
module regfile_write_arbiter #(
   parameter int DATA_WIDTH = 64,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31,
   parameter int CNT_WIDTH  = 8
) (
   input logic                   clk,
   input logic                   reset,
   regfile_write_arbiter_if.slave bus
);
   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);
   localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = '1;

   // Per-source views of the request channels so both buffers share one body
   logic [1:0]            req_valid;
   logic [ADDR_WIDTH-1:0] req_addr [2];
   logic [DATA_WIDTH-1:0] req_data [2];

   // Holding buffers
   logic [1:0]            buf_full_q;
   logic [ADDR_WIDTH-1:0] buf_addr_q [2];
   logic [DATA_WIDTH-1:0] buf_data_q [2];

   logic [1:0]            accept;
   logic [1:0]            drop;
   logic                  grant_vld;
   logic                  grant_src;

   // Registered write port and statistics
   logic                  wr_en_q;
   logic [ADDR_WIDTH-1:0] wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic                  last_grant_q;
   logic [CNT_WIDTH-1:0]  write_count_q;
   logic [CNT_WIDTH-1:0]  write_count_d;
   logic [CNT_WIDTH-1:0]  drop_count_q;
   logic [CNT_WIDTH-1:0]  drop_count_d;
   logic [1:0]            drop_inc;
   logic [CNT_WIDTH:0]    drop_sum;

   assign req_valid   = {bus.req1_valid, bus.req0_valid};
   assign req_addr[0] = bus.req0_addr;
   assign req_addr[1] = bus.req1_addr;
   assign req_data[0] = bus.req0_data;
   assign req_data[1] = bus.req1_data;

   // Ready comes straight from buffer occupancy: no path from valid or grant
   assign bus.req0_ready = ~buf_full_q[0];
   assign bus.req1_ready = ~buf_full_q[1];

   // Round-robin choice on the buffer state present at this edge
   always_comb begin
      grant_vld = |buf_full_q;
      grant_src = 1'b0;
      if (&buf_full_q) begin
         grant_src = ~last_grant_q;
      end else if (buf_full_q[1]) begin
         grant_src = 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_buf
         assign accept[gi] = req_valid[gi] & ~buf_full_q[gi];
         assign drop[gi]   = accept[gi] & (req_addr[gi] == ZERO_ADDR);

         // Buffer fill on a non-zero-register accept, drain on grant. An empty
         // buffer cannot be granted and a full one cannot accept, so the two
         // never collide on the same edge.
         always_ff @(posedge clk) begin
            if (reset) begin
               buf_full_q[gi] <= 1'b0;
               buf_addr_q[gi] <= '0;
               buf_data_q[gi] <= '0;
            end else if (accept[gi] && !drop[gi]) begin
               buf_full_q[gi] <= 1'b1;
               buf_addr_q[gi] <= req_addr[gi];
               buf_data_q[gi] <= req_data[gi];
            end else if (grant_vld && (grant_src == 1'(gi))) begin
               buf_full_q[gi] <= 1'b0;
            end
         end
      end
   endgenerate

   // Saturating counter updates; both sources may drop in the same cycle
   always_comb begin
      drop_inc = {1'b0, drop[0]} + {1'b0, drop[1]};
      drop_sum = {1'b0, drop_count_q} + (CNT_WIDTH + 1)'(drop_inc);
      drop_count_d = drop_sum[CNT_WIDTH] ? CNT_MAX : drop_sum[CNT_WIDTH-1:0];
      write_count_d = write_count_q;
      if (grant_vld && (write_count_q != CNT_MAX)) begin
         write_count_d = write_count_q + CNT_WIDTH'(1);
      end
   end

   // Write port, grant history and statistics registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_en_q       <= 1'b0;
         wr_addr_q     <= '0;
         wr_data_q     <= '0;
         last_grant_q  <= 1'b1;
         write_count_q <= '0;
         drop_count_q  <= '0;
      end else begin
         wr_en_q       <= grant_vld;
         drop_count_q  <= drop_count_d;
         write_count_q <= write_count_d;
         if (grant_vld) begin
            wr_addr_q    <= buf_addr_q[grant_src];
            wr_data_q    <= buf_data_q[grant_src];
            last_grant_q <= grant_src;
         end
      end
   end

   assign bus.wr_en       = wr_en_q;
   assign bus.wr_addr     = wr_addr_q;
   assign bus.wr_data     = wr_data_q;
   assign bus.last_grant  = last_grant_q;
   assign bus.write_count = write_count_q;
   assign bus.drop_count  = drop_count_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// behavioural model of buffers, round-robin order and counters.
module tb_regfile_write_arbiter;
   localparam int DW = 64;
   localparam int AW = 5;
   localparam int CW = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   regfile_write_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) bus ();

   regfile_write_arbiter #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(31), .CNT_WIDTH(CW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          model_ok = 1'b0;
   bit          m_full [2];
   logic [4:0]  m_addr [2];
   logic [63:0] m_data [2];
   bit          m_acc  [2];
   bit          m_wr_en;
   logic [4:0]  m_wr_addr;
   logic [63:0] m_wr_data;
   bit          m_last;
   int          m_wcnt;
   int          m_dcnt;
   int          g_m;
   bit          v_m [2];
   logic [4:0]  a_m [2];
   logic [63:0] d_m [2];

   always @(posedge clk) begin
      v_m[0] = bus.req0_valid; a_m[0] = bus.req0_addr; d_m[0] = bus.req0_data;
      v_m[1] = bus.req1_valid; a_m[1] = bus.req1_addr; d_m[1] = bus.req1_data;
      if (reset) begin
         m_full[0] = 1'b0; m_full[1] = 1'b0;
         m_acc[0] = 1'b0;  m_acc[1] = 1'b0;
         m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
         m_last = 1'b1; m_wcnt = 0; m_dcnt = 0;
         model_ok = 1'b1;
      end else begin
         // whoever holds a write is served; on a tie the source not served last
         g_m = -1;
         if (m_full[0] && m_full[1]) g_m = m_last ? 0 : 1;
         else if (m_full[0]) g_m = 0;
         else if (m_full[1]) g_m = 1;
         for (int s = 0; s < 2; s++) m_acc[s] = v_m[s] && !m_full[s];
         if (g_m >= 0) begin
            m_wr_en = 1'b1;
            m_wr_addr = m_addr[g_m];
            m_wr_data = m_data[g_m];
            m_full[g_m] = 1'b0;
            m_last = (g_m == 1);
            if (m_wcnt < 255) m_wcnt++;
         end else begin
            m_wr_en = 1'b0;
         end
         for (int s = 0; s < 2; s++) begin
            if (m_acc[s]) begin
               if (a_m[s] == 5'd31) begin
                  if (m_dcnt < 255) m_dcnt++;
               end else begin
                  m_full[s] = 1'b1;
                  m_addr[s] = a_m[s];
                  m_data[s] = d_m[s];
               end
            end
         end
      end
   end

   // Register file as seen through the DUT write port
   logic [63:0] dut_rf   [32];
   bit          dut_mark [32];

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (model_ok) begin
         check("wr_en",       64'(bus.wr_en),       64'(m_wr_en));
         check("wr_addr",     64'(bus.wr_addr),     64'(m_wr_addr));
         check("wr_data",     bus.wr_data,          m_wr_data);
         check("last_grant",  64'(bus.last_grant),  64'(m_last));
         check("write_count", 64'(bus.write_count), 64'(m_wcnt));
         check("drop_count",  64'(bus.drop_count),  64'(m_dcnt));
         check("req0_ready",  64'(bus.req0_ready),  64'(!m_full[0]));
         check("req1_ready",  64'(bus.req1_ready),  64'(!m_full[1]));
      end
      if (bus.wr_en === 1'b1) begin
         dut_rf[bus.wr_addr]   = bus.wr_data;
         dut_mark[bus.wr_addr] = 1'b1;
         $display("write X%0d <= %h (src %0d)", bus.wr_addr, bus.wr_data, bus.last_grant);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set0(input bit v, input logic [4:0] a, input logic [63:0] d);
      bus.req0_valid = v; bus.req0_addr = a; bus.req0_data = d;
   endtask

   task automatic set1(input bit v, input logic [4:0] a, input logic [63:0] d);
      bus.req1_valid = v; bus.req1_addr = a; bus.req1_data = d;
   endtask

   task automatic idle();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      idle();
      repeat (n) step();
      reset = 1'b0;
   endtask

   int a0n;
   int a1n;
   int wcyc;

   initial begin
      set0(1'b0, 5'd0, 64'h0);
      set1(1'b0, 5'd0, 64'h0);
      for (int r = 0; r < 32; r++) begin dut_rf[r] = '0; dut_mark[r] = 1'b0; end

      // 1: reset for two cycles, then a single write to X5
      reset = 1'b1;
      repeat (2) step();
      check("rst_wr_en",       64'(bus.wr_en),       64'd0);
      check("rst_ready0",      64'(bus.req0_ready),  64'd1);
      check("rst_ready1",      64'(bus.req1_ready),  64'd1);
      check("rst_last_grant",  64'(bus.last_grant),  64'd1);
      check("rst_write_count", 64'(bus.write_count), 64'd0);
      check("rst_drop_count",  64'(bus.drop_count),  64'd0);
      reset = 1'b0;
      set0(1'b1, 5'd5, 64'h1);
      step();
      idle();
      check("t1_ready0_busy", 64'(bus.req0_ready), 64'd0);
      step();
      check("t1_wr_en",   64'(bus.wr_en),       64'd1);
      check("t1_wr_addr", 64'(bus.wr_addr),     64'd5);
      check("t1_wr_data", bus.wr_data,          64'h1);
      check("t1_wcount",  64'(bus.write_count), 64'd1);

      // 2: contention from a fresh reset (source 0 first)
      do_reset(1);
      set0(1'b1, 5'd1, 64'hAAAA);
      set1(1'b1, 5'd2, 64'hBBBB);
      step();
      idle();
      check("t2_ready0_busy", 64'(bus.req0_ready), 64'd0);
      check("t2_ready1_busy", 64'(bus.req1_ready), 64'd0);
      step();
      check("t2_first_addr", 64'(bus.wr_addr),    64'd1);
      check("t2_first_data", bus.wr_data,         64'hAAAA);
      check("t2_first_last", 64'(bus.last_grant), 64'd0);
      check("t2_ready0_back",64'(bus.req0_ready), 64'd1);
      step();
      check("t2_second_addr", 64'(bus.wr_addr),    64'd2);
      check("t2_second_data", bus.wr_data,         64'hBBBB);
      check("t2_second_last", 64'(bus.last_grant), 64'd1);
      check("t2_ready1_back", 64'(bus.req1_ready), 64'd1);
      step();
      check("t2_idle_wr_en", 64'(bus.wr_en), 64'd0);

      // 3: two back-to-back writes to the zero register
      do_reset(1);
      set1(1'b1, 5'd31, 64'hDEAD);
      step();
      check("t3_ready1_a", 64'(bus.req1_ready), 64'd1);
      step();
      idle();
      check("t3_ready1_b", 64'(bus.req1_ready), 64'd1);
      step();
      check("t3_wr_en",   64'(bus.wr_en),       64'd0);
      check("t3_drops",   64'(bus.drop_count),  64'd2);
      check("t3_wcount",  64'(bus.write_count), 64'd0);

      // 4: both sources streaming with distinct addresses
      do_reset(1);
      a0n = 0; a1n = 16; wcyc = 0;
      set0(1'b1, 5'(a0n), 64'(a0n) + 64'h100);
      set1(1'b1, 5'(a1n), 64'(a1n) + 64'h200);
      for (int c = 0; c < 20; c++) begin
         step();
         if (bus.wr_en === 1'b1) wcyc++;
         if (m_acc[0]) begin a0n++; set0(1'b1, 5'(a0n), 64'(a0n) + 64'h100); end
         if (m_acc[1]) begin a1n++; set1(1'b1, 5'(a1n), 64'(a1n) + 64'h200); end
      end
      idle();
      check("t4_busy_cycles", 64'(wcyc), 64'd19);
      repeat (3) step();

      // 5: reset while both buffers are full
      do_reset(1);
      dut_mark[7] = 1'b0; dut_mark[8] = 1'b0;
      set0(1'b1, 5'd7, 64'h77);
      set1(1'b1, 5'd8, 64'h88);
      step();
      idle();
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t5_wr_en",   64'(bus.wr_en),      64'd0);
      check("t5_last",    64'(bus.last_grant), 64'd1);
      check("t5_ready0",  64'(bus.req0_ready), 64'd1);
      check("t5_ready1",  64'(bus.req1_ready), 64'd1);
      repeat (3) step();
      check("t5_x7_never", 64'(dut_mark[7]), 64'd0);
      check("t5_x8_never", 64'(dut_mark[8]), 64'd0);

      // 6: same destination register with last_grant=0
      do_reset(1);
      set0(1'b1, 5'd4, 64'h44);
      step();
      idle();
      step();
      check("t6_last_pre", 64'(bus.last_grant), 64'd0);
      set0(1'b1, 5'd3, 64'h10);
      set1(1'b1, 5'd3, 64'h20);
      step();
      idle();
      step();
      check("t6_first_data",  bus.wr_data, 64'h20);
      step();
      check("t6_second_data", bus.wr_data, 64'h10);
      step();
      check("t6_x3_final", dut_rf[3], 64'h10);

      // Randomized traffic with held requests until accepted
      do_reset(1);
      for (int c = 0; c < 600; c++) begin
         if (!bus.req0_valid || m_acc[0]) begin
            set0($urandom_range(3) != 0,
                 ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(30)),
                 {$urandom, $urandom});
         end
         if (!bus.req1_valid || m_acc[1]) begin
            set1($urandom_range(3) != 0,
                 ($urandom_range(7) == 0) ? 5'd31 : 5'($urandom_range(30)),
                 {$urandom, $urandom});
         end
         step();
      end

      // Drive the drop counter into saturation
      set0(1'b1, 5'd31, 64'h0);
      set1(1'b1, 5'd31, 64'h0);
      repeat (140) step();
      idle();
      step();
      check("sat_drop_count", 64'(bus.drop_count), 64'd255);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
